qmac_dot: RTL

//  Streaming signed fixed-point dot-product MAC, successor to the single-pair qmac.

---
 rtl/qmac_dot.sv | 94 +++++++++
 1 files changed

// File: rtl/qmac_dot.sv
// qmac_dot: streaming signed fixed-point dot-product MAC with guard-bit accumulator.
// Define QMAC_DOT_SAT_EN to saturate out-of-range results; default build wraps.
module qmac_dot #(
  parameter int N       = 8,
  parameter int Q       = 4,
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_a,
  input  logic [N-1:0]               in_b,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*N-1:0]             result,
  output logic                       overflow,
  output logic [$clog2(MAX_LEN):0]   beat_cnt
);
  localparam int ACC_W = 2*N + $clog2(MAX_LEN);
  localparam int CW    = $clog2(MAX_LEN) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("qmac_dot: Q must lie in [0, N-1]");
  end
  typedef enum logic [1:0] {S_ACC, S_FLUSH, S_OUT} state_t;
  state_t state, state_next;
  logic signed [2*N-1:0]   p_reg, prod_next;
  logic                    p_vld;
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic [2*N-1:0]          result_next;
  logic                    ovf_next, accept;
  logic [ACC_W-2*N:0]      top_bits;
  assign in_ready  = (state == S_ACC);
  assign out_valid = (state == S_OUT);
  assign accept    = in_valid & in_ready;
  assign prod_next = $signed(in_a) * $signed(in_b);
  assign acc_sum   = acc + (p_vld ? {{(ACC_W-2*N){p_reg[2*N-1]}}, p_reg} : '0);
  // Representable in 2N bits iff every bit above the 2N-bit sign bit matches it.
  assign top_bits  = acc_sum[ACC_W-1:2*N-1];
  assign ovf_next  = ~(&top_bits | ~|top_bits);
`ifdef QMAC_DOT_SAT_EN
  assign result_next = ovf_next ? (acc_sum[ACC_W-1] ? {1'b1, {(2*N-1){1'b0}}} : {1'b0, {(2*N-1){1'b1}}})
                                : acc_sum[2*N-1:0];
`else
  assign result_next = acc_sum[2*N-1:0];
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_ACC;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    case (state)
      S_ACC:   state_next = (accept && (in_last || beat_cnt == LAST_CNT)) ? S_FLUSH : S_ACC;
      S_FLUSH: state_next = S_OUT;
      S_OUT:   state_next = out_ready ? S_ACC : S_OUT;
      default: state_next = S_ACC;
    endcase
    if (clear) state_next = S_ACC;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      p_reg    <= '0;
      p_vld    <= 1'b0;
      beat_cnt <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      p_vld    <= 1'b0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) p_reg <= prod_next;
      if (state == S_OUT && out_ready) begin
        acc      <= '0;
        beat_cnt <= '0;
      end else begin
        acc <= acc_sum;
        if (accept) beat_cnt <= beat_cnt + CW'(1);
      end
      // The final product lands in acc_sum during S_FLUSH, so the result is latched there.
      if (state == S_FLUSH) begin
        result   <= result_next;
        overflow <= ovf_next;
      end
    end
  end
endmodule
